// File: rtl/ltc2986_ctrl.sv
// LTC2986 transaction sequencer.
// Sits in front of a byte-level SPI master. For each measurement request it
// writes the channel-assignment word (first request after reset only),
// starts a conversion, polls the command-status register until the part
// reports done, reads the 32-bit result and hands temperature and fault
// bytes to downstream logic.
module ltc2986_ctrl #(
    parameter int          CH        = 4,
    parameter logic [31:0] CH_CFG    = 32'h608A_C000,
    parameter int          POLL_GAP  = 100000,
    parameter int          MAX_POLLS = 2000
) (
    input  logic               clk,
    input  logic               reset1,
    input  logic               start,
    output logic               busy,
    output logic               data_valid,
    output logic signed [23:0] temp_data,
    output logic        [7:0]  fault,
    output logic               timeout_err,
    output logic        [7:0]  tx0,
    output logic        [7:0]  tx1,
    output logic        [7:0]  tx2,
    output logic        [7:0]  tx3,
    output logic        [7:0]  tx4,
    output logic        [7:0]  tx5,
    output logic        [7:0]  tx6,
    output logic        [2:0]  spi_n,
    output logic               spi_go,
    input  logic        [7:0]  rx0,
    input  logic        [7:0]  rx1,
    input  logic        [7:0]  rx2,
    input  logic        [7:0]  rx3,
    input  logic        [7:0]  rx4,
    input  logic        [7:0]  rx5,
    input  logic        [7:0]  rx6,
    input  logic               spi_ok
);

    typedef enum logic [3:0] {
        IDLE,
        CFG_LOAD,
        CFG_WAIT,
        CONV_LOAD,
        CONV_WAIT,
        GAP,
        POLL_LOAD,
        POLL_WAIT,
        READ_LOAD,
        READ_WAIT,
        DONE,
        ERR
    } state_t;

    // Counter widths: the poll counter must hold MAX_POLLS itself, the gap
    // counter only runs 0..POLL_GAP-1.
    localparam int PCW = $clog2(MAX_POLLS + 1);
    localparam int GCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [PCW-1:0] POLL_LIMIT = PCW'(MAX_POLLS);
    localparam logic [GCW-1:0] GAP_LAST   = GCW'(POLL_GAP - 1);

    // LTC2986 opcodes and register addresses (low address byte only; the
    // high byte is 0x02 for channel assignment and 0x00 for results and
    // status). CH <= 10 keeps all sums inside 8 bits.
    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] CFG_ADDR  = 8'(4 * (CH - 1));
    localparam logic [7:0] RES_ADDR  = 8'(16 + 4 * (CH - 1));
    localparam logic [7:0] CONV_CMD  = 8'h80 | 8'(CH);

    state_t                state, state_nxt;
    logic                  cfg_done, cfg_done_nxt;
    logic [PCW-1:0]        poll_cnt, poll_cnt_nxt;
    logic [PCW-1:0]        poll_inc;
    logic [GCW-1:0]        gap_cnt, gap_cnt_nxt;
    logic                  timeout_err_nxt;
    logic signed [23:0]    temp_data_nxt;
    logic [7:0]            fault_nxt;
    logic                  conv_done;

    // rx0..rx2 only echo the command/address phase and carry no data.
    logic unused_rx;
    assign unused_rx = ^{rx0, rx1, rx2};

    // Status byte: bit7 = start (still running), bit6 = done.
    assign conv_done = (rx3[7] == 1'b0) && (rx3[6] == 1'b1);
    assign poll_inc  = poll_cnt + PCW'(1);

    // Next-state, frame contents and handshake outputs decoded from state.
    always_comb begin
        state_nxt       = state;
        cfg_done_nxt    = cfg_done;
        poll_cnt_nxt    = poll_cnt;
        gap_cnt_nxt     = gap_cnt;
        timeout_err_nxt = timeout_err;
        temp_data_nxt   = temp_data;
        fault_nxt       = fault;
        tx0             = 8'h00;
        tx1             = 8'h00;
        tx2             = 8'h00;
        tx3             = 8'h00;
        tx4             = 8'h00;
        tx5             = 8'h00;
        tx6             = 8'h00;
        spi_n           = 3'd0;
        spi_go          = 1'b0;
        busy            = 1'b1;
        data_valid      = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    timeout_err_nxt = 1'b0;
                    poll_cnt_nxt    = '0;
                    state_nxt       = cfg_done ? CONV_LOAD : CFG_LOAD;
                end
            end

            CFG_LOAD, CFG_WAIT: begin
                spi_n = 3'd7;
                tx0   = OP_WRITE;
                tx1   = 8'h02;
                tx2   = CFG_ADDR;
                tx3   = CH_CFG[31:24];
                tx4   = CH_CFG[23:16];
                tx5   = CH_CFG[15:8];
                tx6   = CH_CFG[7:0];
                if (state == CFG_LOAD) begin
                    spi_go    = 1'b1;
                    state_nxt = CFG_WAIT;
                end else if (spi_ok) begin
                    cfg_done_nxt = 1'b1;
                    state_nxt    = CONV_LOAD;
                end
            end

            CONV_LOAD, CONV_WAIT: begin
                spi_n = 3'd4;
                tx0   = OP_WRITE;
                tx1   = 8'h00;
                tx2   = 8'h00;
                tx3   = CONV_CMD;
                if (state == CONV_LOAD) begin
                    spi_go    = 1'b1;
                    state_nxt = CONV_WAIT;
                end else if (spi_ok) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = GAP;
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = POLL_LOAD;
                end else begin
                    gap_cnt_nxt = gap_cnt + GCW'(1);
                end
            end

            POLL_LOAD, POLL_WAIT: begin
                spi_n = 3'd4;
                tx0   = OP_READ;
                if (state == POLL_LOAD) begin
                    spi_go    = 1'b1;
                    state_nxt = POLL_WAIT;
                end else if (spi_ok) begin
                    if (conv_done) begin
                        state_nxt = READ_LOAD;
                    end else begin
                        poll_cnt_nxt = poll_inc;
                        gap_cnt_nxt  = '0;
                        if (poll_inc == POLL_LIMIT) begin
                            timeout_err_nxt = 1'b1;
                            state_nxt       = ERR;
                        end else begin
                            state_nxt = GAP;
                        end
                    end
                end
            end

            READ_LOAD, READ_WAIT: begin
                spi_n = 3'd7;
                tx0   = OP_READ;
                tx2   = RES_ADDR;
                if (state == READ_LOAD) begin
                    spi_go    = 1'b1;
                    state_nxt = READ_WAIT;
                end else if (spi_ok) begin
                    fault_nxt     = rx3;
                    temp_data_nxt = signed'({rx4, rx5, rx6});
                    state_nxt     = DONE;
                end
            end

            DONE: begin
                busy       = 1'b0;
                data_valid = 1'b1;
                state_nxt  = IDLE;
            end

            ERR: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end

            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Sequencer state and control counters; reset aborts any transaction.
    always_ff @(posedge clk or negedge reset1) begin
        if (!reset1) begin
            state       <= IDLE;
            cfg_done    <= 1'b0;
            poll_cnt    <= '0;
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            cfg_done    <= cfg_done_nxt;
            poll_cnt    <= poll_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

    // Measurement result registers, loaded when the result frame completes.
    always_ff @(posedge clk or negedge reset1) begin
        if (!reset1) begin
            temp_data <= '0;
            fault     <= '0;
        end else begin
            temp_data <= temp_data_nxt;
            fault     <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_ltc2986_ctrl.sv
// Bench for ltc2986_ctrl: a behavioural SPI master + LTC2986 model answers
// each frame; expected frames are queued before each request and checked
// as the sequencer issues them.
module tb_ltc2986_ctrl;

    logic        clk = 1'b0;
    logic        reset1 = 1'b1;
    logic        start = 1'b0;
    logic        busy, data_valid, timeout_err, spi_go;
    logic [23:0] temp_data;
    logic [7:0]  fault;
    logic [7:0]  tx0, tx1, tx2, tx3, tx4, tx5, tx6;
    logic [2:0]  spi_n;
    logic [7:0]  rx0 = 8'h00, rx1 = 8'h00, rx2 = 8'h00, rx3 = 8'h00;
    logic [7:0]  rx4 = 8'h00, rx5 = 8'h00, rx6 = 8'h00;
    logic        spi_ok = 1'b0;

    ltc2986_ctrl #(
        .CH(4), .CH_CFG(32'h608A_C000), .POLL_GAP(4), .MAX_POLLS(3)
    ) dut (
        .clk(clk), .reset1(reset1), .start(start), .busy(busy),
        .data_valid(data_valid), .temp_data(temp_data), .fault(fault),
        .timeout_err(timeout_err),
        .tx0(tx0), .tx1(tx1), .tx2(tx2), .tx3(tx3), .tx4(tx4), .tx5(tx5), .tx6(tx6),
        .spi_n(spi_n), .spi_go(spi_go),
        .rx0(rx0), .rx1(rx1), .rx2(rx2), .rx3(rx3), .rx4(rx4), .rx5(rx5), .rx6(rx6),
        .spi_ok(spi_ok)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  n;
        logic [55:0] b;
    } frame_t;

    typedef struct {
        bit          cfg;
        int          done_poll;
        logic [7:0]  stuck;
        logic [31:0] result;
        int          exp_dv;
        logic [23:0] exp_temp;
        logic [7:0]  exp_fault;
        logic        exp_to;
    } row_t;

    localparam frame_t F_CFG  = {3'd7, 56'h02_02_0C_60_8A_C0_00};
    localparam frame_t F_CONV = {3'd4, 56'h02_00_00_84_00_00_00};
    localparam frame_t F_POLL = {3'd4, 56'h03_00_00_00_00_00_00};
    localparam frame_t F_READ = {3'd7, 56'h03_00_1C_00_00_00_00};

    int errors = 0;
    int checks = 0;

    frame_t sb[$];

    // LTC model controls
    int          m_done_poll = 0;
    int          m_poll_k = 0;
    logic [7:0]  m_stuck = 8'h84;
    logic [31:0] m_result = 32'h0;
    int          frames_seen = 0;
    bit          read_seen = 0;
    int          dv_count = 0;

    // model internals
    bit          outstanding = 0;
    bit          go_bad = 0;
    bit          stab_bad = 0;
    int          lat = 0;
    frame_t      cur;
    frame_t      now_f;
    frame_t      exp_f;
    logic [55:0] resp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // SPI master + LTC2986 model
    always begin
        @(posedge clk);
        #1;
        spi_ok = 1'b0;
        now_f = {spi_n, tx0, tx1, tx2, tx3, tx4, tx5, tx6};
        if (!reset1) begin
            outstanding = 0;
        end else if (outstanding) begin
            if (spi_go !== 1'b0) go_bad = 1;
            if (now_f !== cur) stab_bad = 1;
            lat--;
            if (lat == 0) begin
                chk("go_one_cycle", {63'd0, go_bad}, 64'd0);
                chk("tx_stable", {63'd0, stab_bad}, 64'd0);
                {rx0, rx1, rx2, rx3, rx4, rx5, rx6} = resp;
                spi_ok = 1'b1;
                outstanding = 0;
            end
        end else if (spi_go === 1'b1) begin
            cur = now_f;
            frames_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got %h expected none", cur);
            end else begin
                exp_f = sb.pop_front();
                chk("frame", 64'(cur), 64'(exp_f));
            end
            resp = '0;
            if (tx0 == 8'h03 && spi_n == 3'd4) begin
                m_poll_k++;
                resp[31:24] = (m_poll_k == m_done_poll) ? 8'h44 : m_stuck;
            end else if (tx0 == 8'h03 && spi_n == 3'd7) begin
                resp[31:0] = m_result;
                read_seen = 1;
            end
            go_bad = 0;
            stab_bad = 0;
            lat = 4;
            outstanding = 1;
        end
    end

    // data_valid pulse counter
    always begin
        @(posedge clk);
        #1;
        if (data_valid === 1'b1) dv_count++;
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", {63'd0, busy}, 64'd0);
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (frames_seen < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("frames_reached", {63'd0, frames_seen >= n}, 64'd1);
    endtask

    task automatic run_row(input row_t r);
        int npoll;
        int dv0;
        if (r.cfg) sb.push_back(F_CFG);
        sb.push_back(F_CONV);
        npoll = (r.done_poll == 0) ? 3 : r.done_poll;
        for (int p = 0; p < npoll; p++) sb.push_back(F_POLL);
        if (r.done_poll != 0) sb.push_back(F_READ);
        m_done_poll = r.done_poll;
        m_stuck = r.stuck;
        m_result = r.result;
        m_poll_k = 0;
        dv0 = dv_count;
        pulse_start();
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("timeout_cleared", {63'd0, timeout_err}, 64'd0);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("frames_left", 64'(sb.size()), 64'd0);
        chk("dv_pulses", 64'(dv_count - dv0), 64'(r.exp_dv));
        chk("temp_data", {40'd0, temp_data}, {40'd0, r.exp_temp});
        chk("fault", {56'd0, fault}, {56'd0, r.exp_fault});
        chk("timeout_err", {63'd0, timeout_err}, {63'd0, r.exp_to});
        chk("busy_end", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t rows[4];
        row_t rr;
        int   base;
        int   dv0;
        int   k;
        bit   go_seen;

        rows[0] = '{1'b1, 3, 8'h84, 32'h0100_6400, 1, 24'h006400, 8'h01, 1'b0};
        rows[1] = '{1'b0, 2, 8'hC4, 32'h01FF_EC00, 1, 24'hFFEC00, 8'h01, 1'b0};
        rows[2] = '{1'b0, 0, 8'h84, 32'h0000_0000, 0, 24'hFFEC00, 8'h01, 1'b1};
        rows[3] = '{1'b0, 1, 8'h84, 32'h027F_FFFF, 1, 24'h7FFFFF, 8'h02, 1'b0};

        // asynchronous reset state
        #2 reset1 = 1'b0;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_spi_go", {63'd0, spi_go}, 64'd0);
        chk("rst_frame", 64'({spi_n, tx0, tx1, tx2, tx3, tx4, tx5, tx6}), 64'd0);
        chk("rst_outputs", {38'd0, data_valid, timeout_err, temp_data}, 64'd0);
        chk("rst_fault", {56'd0, fault}, 64'd0);
        repeat (3) @(negedge clk);
        reset1 = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) run_row(rows[i]);

        // start while busy and start in the DONE cycle are both dropped
        sb.push_back(F_CONV);
        sb.push_back(F_POLL);
        sb.push_back(F_POLL);
        sb.push_back(F_READ);
        m_done_poll = 2;
        m_stuck = 8'h84;
        m_result = 32'h0100_0400;
        m_poll_k = 0;
        dv0 = dv_count;
        base = frames_seen;
        pulse_start();
        wait_frames(base + 2);
        repeat (3) @(negedge clk);
        chk("busy_mid_poll", {63'd0, busy}, 64'd1);
        pulse_start();
        k = 0;
        while (data_valid !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("dv_seen", {63'd0, data_valid}, 64'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_done", {63'd0, busy}, 64'd0);
        repeat (20) @(negedge clk);
        chk("ignore_busy", {63'd0, busy}, 64'd0);
        chk("ignore_frames", 64'(sb.size()), 64'd0);
        chk("ignore_count", 64'(frames_seen - base), 64'd4);
        chk("ignore_dv", 64'(dv_count - dv0), 64'd1);
        chk("ignore_temp", {40'd0, temp_data}, 64'h000400);

        // reset during READ_WAIT
        sb.push_back(F_CONV);
        sb.push_back(F_POLL);
        sb.push_back(F_READ);
        m_done_poll = 1;
        m_result = 32'h0100_1000;
        m_poll_k = 0;
        read_seen = 0;
        dv0 = dv_count;
        pulse_start();
        k = 0;
        while (!read_seen && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("read_reached", {63'd0, read_seen}, 64'd1);
        @(posedge clk);
        #3 reset1 = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_spi_go", {63'd0, spi_go}, 64'd0);
        chk("mid_rst_frame", 64'({spi_n, tx0, tx1, tx2, tx3, tx4, tx5, tx6}), 64'd0);
        chk("mid_rst_temp", {40'd0, temp_data}, 64'd0);
        chk("mid_rst_flags", {56'd0, fault}, 64'd0);
        go_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (spi_go !== 1'b0) go_seen = 1;
        end
        chk("rst_no_go", {63'd0, go_seen}, 64'd0);
        reset1 = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_no_dv", 64'(dv_count - dv0), 64'd0);
        chk("rst_frames_left", 64'(sb.size()), 64'd0);

        rr = '{1'b1, 1, 8'h84, 32'h0100_6400, 1, 24'h006400, 8'h01, 1'b0};
        run_row(rr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
